// File: rtl/flow_ctrl_pause_req.sv
// flow_ctrl_pause_req: transmit-domain XOFF/XON request generator.
// Watches RX FIFO free space and asks the MAC TX controller for PAUSE frames.
// XOFF carries pause_time, XON carries 0.
// XOFF is refreshed before the partner's pause timer runs out.
// Optional: define FLOW_CTRL_PAUSE_STATS_EN to build the saturating XOFF/XON frame counters;
// otherwise xoff_count/xon_count are tied to 0.
`timescale 1ns/1ps
module flow_ctrl_pause_req #(
    parameter logic [15:0] REFRESH_MARGIN = 16'd16
) (
    input  logic        tx_clk,
    input  logic        rst,
    input  logic        pause_request_en,
    input  logic [15:0] pause_time,
    input  logic [15:0] pause_thresh,
    input  logic [15:0] resume_thresh,
    input  logic [15:0] rx_fifo_space,
    output logic        pause_req,
    output logic [15:0] pause_quanta_out,
    input  logic        pause_ack,
    output logic        pause_active,
    output logic [15:0] xoff_count,
    output logic [15:0] xon_count
);

    typedef enum logic [1:0] {IDLE, SEND_XOFF, HOLD, SEND_XON} state_t;

    state_t      state, state_nxt;
    logic [15:0] space_r;
    logic [21:0] refresh_cnt, refresh_cnt_nxt;
    logic [15:0] quanta_r, quanta_nxt;
    logic [15:0] refresh_base;
    logic        xon_cond;

    // Refresh period in quanta, saturating at 1 so a short pause_time never underflows.
    assign refresh_base = (pause_time > REFRESH_MARGIN) ? (pause_time - REFRESH_MARGIN) : 16'd1;
    assign xon_cond     = ~pause_request_en | (space_r >= resume_thresh);

    // State, refresh counter, latched quanta and sampled FIFO space.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            refresh_cnt <= '0;
            quanta_r    <= '0;
            space_r     <= '0;
        end else begin
            state       <= state_nxt;
            refresh_cnt <= refresh_cnt_nxt;
            quanta_r    <= quanta_nxt;
            space_r     <= rx_fifo_space;
        end
    end

    // Next-state logic; quanta is captured on entry to a send state so it stays stable until ack.
    always_comb begin
        state_nxt       = state;
        refresh_cnt_nxt = refresh_cnt;
        quanta_nxt      = quanta_r;
        case (state)
            IDLE: begin
                if (pause_request_en && (pause_time != 16'd0) && (space_r < pause_thresh)) begin
                    state_nxt  = SEND_XOFF;
                    quanta_nxt = pause_time;
                end
            end
            SEND_XOFF: begin
                if (pause_ack) begin
                    state_nxt       = HOLD;
                    refresh_cnt_nxt = {refresh_base, 6'b0};
                    quanta_nxt      = '0;
                end
            end
            HOLD: begin
                // XON wins over an expiring refresh counter.
                if (xon_cond) begin
                    state_nxt  = SEND_XON;
                    quanta_nxt = '0;
                end else if (refresh_cnt == 22'd0) begin
                    state_nxt  = SEND_XOFF;
                    quanta_nxt = pause_time;
                end else begin
                    refresh_cnt_nxt = refresh_cnt - 22'd1;
                end
            end
            SEND_XON: begin
                if (pause_ack) begin
                    state_nxt  = IDLE;
                    quanta_nxt = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                quanta_nxt = '0;
            end
        endcase
    end

    assign pause_req        = (state == SEND_XOFF) | (state == SEND_XON);
    assign pause_quanta_out = quanta_r;
    assign pause_active     = (state == HOLD) | (state == SEND_XON);

`ifdef FLOW_CTRL_PAUSE_STATS_EN
    logic [15:0] xoff_cnt_r, xon_cnt_r;

    // Count acked frames, saturating at all-ones.
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            xoff_cnt_r <= '0;
            xon_cnt_r  <= '0;
        end else begin
            if ((state == SEND_XOFF) && pause_ack && (xoff_cnt_r != 16'hFFFF))
                xoff_cnt_r <= xoff_cnt_r + 16'd1;
            if ((state == SEND_XON) && pause_ack && (xon_cnt_r != 16'hFFFF))
                xon_cnt_r <= xon_cnt_r + 16'd1;
        end
    end

    assign xoff_count = xoff_cnt_r;
    assign xon_count  = xon_cnt_r;
`else
    assign xoff_count = '0;
    assign xon_count  = '0;
`endif

endmodule

// File: tb/tb_flow_ctrl_pause_req.sv
// Directed bench for flow_ctrl_pause_req.
`timescale 1ns/1ps
module tb_flow_ctrl_pause_req;

    logic        tx_clk = 1'b0;
    logic        rst, en, ack;
    logic [15:0] pause_time, pause_thresh, resume_thresh, space;
    logic        pause_req, pause_active;
    logic [15:0] quanta, xoff_count, xon_count;
    int          checks = 0;
    int          failures = 0;

`ifdef FLOW_CTRL_PAUSE_STATS_EN
    localparam int EXP_XOFF = 3;
    localparam int EXP_XON  = 1;
`else
    localparam int EXP_XOFF = 0;
    localparam int EXP_XON  = 0;
`endif

    always #5 tx_clk = ~tx_clk;

    flow_ctrl_pause_req dut (
        .tx_clk          (tx_clk),
        .rst             (rst),
        .pause_request_en(en),
        .pause_time      (pause_time),
        .pause_thresh    (pause_thresh),
        .resume_thresh   (resume_thresh),
        .rx_fifo_space   (space),
        .pause_req       (pause_req),
        .pause_quanta_out(quanta),
        .pause_ack       (ack),
        .pause_active    (pause_active),
        .xoff_count      (xoff_count),
        .xon_count       (xon_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic apply_reset();
        en  = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    // Edges waited until pause_req is seen high; -1 on timeout.
    task automatic wait_req(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (pause_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ack = 1'b0;
        pause_time = 16'd0; pause_thresh = 16'd64; resume_thresh = 16'd128; space = 16'd200;
        #2;
        checks++;
        if ({pause_req, pause_active, quanta, xoff_count, xon_count} !== 35'd0) begin
            failures++;
            $display("FAIL reset_async: got req=%0b act=%0b q=%0d xoff=%0d xon=%0d exp all 0",
                     pause_req, pause_active, quanta, xoff_count, xon_count);
        end
        tick(2);
        rst = 1'b0;
        tick(2);
        // ack without a request is ignored
        do_ack();
        tick(2);
        checks++;
        if ({pause_req, pause_active, xoff_count} !== 18'd0) begin
            failures++;
            $display("FAIL stray_ack: got req=%0b act=%0b xoff=%0d exp 0", pause_req, pause_active, xoff_count);
        end
    endtask

    task automatic test_xoff();
        pause_time = 16'd100;
        en = 1'b1;
        tick(3);
        checks++;
        if (pause_req !== 1'b0) begin
            failures++;
            $display("FAIL above_thresh: got req=%0b exp 0", pause_req);
        end
        space = 16'd32;
        tick(1);
        checks++;
        if (pause_req !== 1'b0) begin
            failures++;
            $display("FAIL xoff_latency1: got req=%0b exp 0", pause_req);
        end
        tick(1);
        checks++;
        if (pause_req !== 1'b1 || quanta !== 16'd100 || pause_active !== 1'b0) begin
            failures++;
            $display("FAIL xoff_req: got req=%0b q=%0d act=%0b exp req=1 q=100 act=0", pause_req, quanta, pause_active);
        end
        do_ack();
        checks++;
        if (pause_req !== 1'b0 || pause_active !== 1'b1) begin
            failures++;
            $display("FAIL xoff_acked: got req=%0b act=%0b exp req=0 act=1", pause_req, pause_active);
        end
    endtask

    task automatic test_refresh();
        int n;
        wait_req(6000, n);
        checks++;
        if (n < 5375 || n > 5377) begin
            failures++;
            $display("FAIL refresh_interval: got %0d cycles exp 5376 +/-1", n);
        end
        checks++;
        if (quanta !== 16'd100) begin
            failures++;
            $display("FAIL refresh_quanta: got %0d exp 100", quanta);
        end
        do_ack();
    endtask

    task automatic test_xon_priority();
        int n;
        space = 16'd32; pause_time = 16'd10;
        apply_reset();
        en = 1'b1;
        wait_req(10, n);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL prio_first_req: got %0d exp 1", n);
        end
        do_ack();
        tick(63);
        space = 16'd128;
        tick(1);
        checks++;
        if (pause_req !== 1'b0 || pause_active !== 1'b1) begin
            failures++;
            $display("FAIL prio_hold: got req=%0b act=%0b exp req=0 act=1", pause_req, pause_active);
        end
        tick(1);
        checks++;
        if (pause_req !== 1'b1 || quanta !== 16'd0 || pause_active !== 1'b1) begin
            failures++;
            $display("FAIL prio_xon: got req=%0b q=%0d act=%0b exp req=1 q=0 act=1", pause_req, quanta, pause_active);
        end
        do_ack();
        tick(5);
        checks++;
        if (pause_req !== 1'b0 || pause_active !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle: got req=%0b act=%0b exp 0 0", pause_req, pause_active);
        end
    endtask

    task automatic test_ack_withhold();
        int n;
        bit stable;
        space = 16'd32; pause_time = 16'd100;
        apply_reset();
        en = 1'b1;
        wait_req(10, n);
        stable = (n > 0);
        for (int i = 0; i < 50; i++) begin
            space = (i % 2 == 1) ? 16'd200 : 16'd32;
            en    = (i % 3 != 0);
            tick(1);
            if (pause_req !== 1'b1 || quanta !== 16'd100) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL withhold_stable: got req=%0b q=%0d exp req=1 q=100", pause_req, quanta);
        end
        en = 1'b0;
        do_ack();
        checks++;
        if (pause_req !== 1'b0 || pause_active !== 1'b1) begin
            failures++;
            $display("FAIL withhold_hold: got req=%0b act=%0b exp req=0 act=1", pause_req, pause_active);
        end
        tick(1);
        checks++;
        if (pause_req !== 1'b1 || quanta !== 16'd0) begin
            failures++;
            $display("FAIL withhold_xon: got req=%0b q=%0d exp req=1 q=0", pause_req, quanta);
        end
        do_ack();
        tick(4);
        checks++;
        if (pause_req !== 1'b0 || pause_active !== 1'b0) begin
            failures++;
            $display("FAIL withhold_idle: got req=%0b act=%0b exp 0 0", pause_req, pause_active);
        end
    endtask

    task automatic test_short_pause();
        int n;
        bit seen;
        space = 16'd32; pause_time = 16'd10;
        apply_reset();
        en = 1'b1;
        wait_req(10, n);
        do_ack();
        wait_req(200, n);
        checks++;
        if (n < 63 || n > 65) begin
            failures++;
            $display("FAIL short_refresh: got %0d cycles exp 64 +/-1", n);
        end
        do_ack();
        pause_time = 16'd0;
        apply_reset();
        en = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            tick(1);
            if (pause_req) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL zero_pause_time: got req seen=%0b exp 0", seen);
        end
    endtask

    task automatic test_stats_and_reset();
        int n;
        space = 16'd32; pause_time = 16'd10;
        apply_reset();
        en = 1'b1;
        wait_req(10, n);
        do_ack();
        wait_req(200, n);
        do_ack();
        wait_req(200, n);
        do_ack();
        space = 16'd200;
        wait_req(10, n);
        checks++;
        if (n != 2 || quanta !== 16'd0) begin
            failures++;
            $display("FAIL stats_xon_req: got n=%0d q=%0d exp n=2 q=0", n, quanta);
        end
        do_ack();
        tick(1);
        checks++;
        if (xoff_count !== 16'(EXP_XOFF) || xon_count !== 16'(EXP_XON)) begin
            failures++;
            $display("FAIL stats_counts: got xoff=%0d xon=%0d exp xoff=%0d xon=%0d",
                     xoff_count, xon_count, EXP_XOFF, EXP_XON);
        end
        space = 16'd32;
        wait_req(10, n);
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL mid_req: got %0d exp 2", n);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pause_req, pause_active, quanta, xoff_count, xon_count} !== 35'd0) begin
            failures++;
            $display("FAIL reset_mid: got req=%0b act=%0b q=%0d xoff=%0d xon=%0d exp all 0",
                     pause_req, pause_active, quanta, xoff_count, xon_count);
        end
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_xoff();
        test_refresh();
        test_xon_priority();
        test_ack_withhold();
        test_short_pause();
        test_stats_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
